// File: rtl/trail_pkg.sv
`default_nettype none
// ============================================================================
// Module   : trail_pkg (package)
// Purpose  : Shared types and helpers for the bird trail buffer.
//            - trail_state_t : recorder state encoding (IDLE/RECORD/HOLD)
//            - calc_w()      : bit width needed to index n items (minimum 1);
//                              gives AGE_W = $clog2(NUM_DOTS) for NUM_DOTS >= 2
// Revision : 1.0  initial release
// ============================================================================
package trail_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECORD = 2'd1,
    HOLD   = 2'd2
  } trail_state_t;

  function automatic int calc_w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/trail_hit_test.sv
`default_nettype none
// ============================================================================
// Module   : trail_hit_test
// Purpose  : Combinational per-pixel hit test against all trail dots, with a
//            minimum-age encoder so the newest overlapping dot wins.
// Ports    : i_valid  - per-entry valid bits
//            i_dotX/Y - per-entry dot top-left (signed)
//            i_wrPtr  - ring write pointer (next slot to be written)
//            i_pixelX/Y - current scan pixel (signed)
//            o_hit    - pixel lies inside at least one valid dot
//            o_age    - minimum age among hits, 0 when no hit
// Revision : 1.0  initial release
// ============================================================================
module trail_hit_test
  import trail_pkg::*;
#(
  parameter int NUM_DOTS = 8,
  parameter int DOT_SIZE = 4,
  parameter int COORD_W  = 11
) (
  input  logic [NUM_DOTS-1:0]          i_valid,
  input  logic signed [COORD_W-1:0]    i_dotX [NUM_DOTS],
  input  logic signed [COORD_W-1:0]    i_dotY [NUM_DOTS],
  input  logic [$clog2(NUM_DOTS)-1:0]  i_wrPtr,
  input  logic signed [COORD_W-1:0]    i_pixelX,
  input  logic signed [COORD_W-1:0]    i_pixelY,
  output logic                         o_hit,
  output logic [$clog2(NUM_DOTS)-1:0]  o_age
);

  localparam int AGE_W = calc_w(NUM_DOTS);
  localparam logic signed [COORD_W:0] c_size = (COORD_W+1)'(DOT_SIZE);

  // One extra bit of headroom so dot+size near the edge cannot wrap.
  logic signed [COORD_W:0] w_px;
  logic signed [COORD_W:0] w_py;
  logic [NUM_DOTS-1:0]     w_hitVec;
  logic [AGE_W-1:0]        w_ageVec [NUM_DOTS];
  logic                    w_found;
  logic [AGE_W-1:0]        w_best;

  assign w_px = {i_pixelX[COORD_W-1], i_pixelX};
  assign w_py = {i_pixelY[COORD_W-1], i_pixelY};

  for (genvar i = 0; i < NUM_DOTS; i++) begin : g_dot
    logic signed [COORD_W:0] w_x;
    logic signed [COORD_W:0] w_y;
    assign w_x = {i_dotX[i][COORD_W-1], i_dotX[i]};
    assign w_y = {i_dotY[i][COORD_W-1], i_dotY[i]};
    assign w_hitVec[i] = i_valid[i] &&
                         (w_px >= w_x) && (w_px < w_x + c_size) &&
                         (w_py >= w_y) && (w_py < w_y + c_size);
    // Slot written last has age 0; wraps naturally as NUM_DOTS is a power of two.
    assign w_ageVec[i] = i_wrPtr - AGE_W'(1) - AGE_W'(i);
  end

  always_comb begin
    w_found = 1'b0;
    w_best  = '0;
    for (int i = 0; i < NUM_DOTS; i++) begin
      if (w_hitVec[i] && (!w_found || (w_ageVec[i] < w_best))) begin
        w_found = 1'b1;
        w_best  = w_ageVec[i];
      end
    end
  end

  assign o_hit = w_found;
  assign o_age = w_best;

endmodule
`default_nettype wire

// File: rtl/bird_trail_buffer.sv
`default_nettype none
// ============================================================================
// Module   : bird_trail_buffer
// Purpose  : Records the slingshot bird's centre every SAMPLE_FRAMES frames in
//            a NUM_DOTS ring buffer and answers per-pixel trail queries with
//            one clock of latency, including an age rank for fading.
// Ports    : clk, resetN (async, active-low)
//            i_startOfFrame - one-cycle pulse per frame
//            i_birdX/Y      - bird top-left (signed)
//            i_birdActive   - bird in flight (level)
//            i_collision    - bird collision
//            i_clearTrail   - synchronous clear request
//            i_pixelX/Y     - scan pixel (signed)
//            o_trailDR      - registered: pixel on a valid dot
//            o_dotAge       - registered: age of newest hit dot, 0 = newest
//            o_dotCount     - number of valid dots
// Revision : 1.0  initial release
// ============================================================================
module bird_trail_buffer
  import trail_pkg::*;
#(
  parameter int NUM_DOTS          = 8,
  parameter int SAMPLE_FRAMES     = 3,
  parameter int DOT_SIZE          = 4,
  parameter int CENTER_OFFSET     = 8,
  parameter int COORD_W           = 11,
  parameter int KEEP_ON_COLLISION = 1
) (
  input  logic                        clk,
  input  logic                        resetN,
  input  logic                        i_startOfFrame,
  input  logic signed [COORD_W-1:0]   i_birdX,
  input  logic signed [COORD_W-1:0]   i_birdY,
  input  logic                        i_birdActive,
  input  logic                        i_collision,
  input  logic                        i_clearTrail,
  input  logic signed [COORD_W-1:0]   i_pixelX,
  input  logic signed [COORD_W-1:0]   i_pixelY,
  output logic                        o_trailDR,
  output logic [$clog2(NUM_DOTS)-1:0] o_dotAge,
  output logic [$clog2(NUM_DOTS):0]   o_dotCount
);

  localparam int AGE_W = calc_w(NUM_DOTS);
  localparam int FC_W  = calc_w(SAMPLE_FRAMES);
  localparam logic signed [COORD_W:0] c_sampleOfs = (COORD_W+1)'(CENTER_OFFSET - DOT_SIZE/2);
  localparam logic [FC_W-1:0]         c_lastFrame = FC_W'(SAMPLE_FRAMES - 1);
  localparam logic [AGE_W:0]          c_full      = (AGE_W+1)'(NUM_DOTS);

  trail_state_t r_state, w_next;

  logic [NUM_DOTS-1:0]        r_valid;
  logic signed [COORD_W-1:0]  r_dotX [NUM_DOTS];
  logic signed [COORD_W-1:0]  r_dotY [NUM_DOTS];
  logic [AGE_W-1:0]           r_wrPtr;
  logic [FC_W-1:0]            r_frameCnt;
  logic [AGE_W:0]             r_dotCount;
  logic                       r_birdActPrev;
  logic                       r_trailDR;
  logic [AGE_W-1:0]           r_dotAge;

  logic                       w_clear;
  logic                       w_write;
  logic                       w_frameInc;
  logic signed [COORD_W-1:0]  w_sampX;
  logic signed [COORD_W-1:0]  w_sampY;
  logic                       w_hit;
  logic [AGE_W-1:0]           w_age;

  // Dot top-left = bird centre minus half a dot, wrapped back to COORD_W.
  assign w_sampX = COORD_W'({i_birdX[COORD_W-1], i_birdX} + c_sampleOfs);
  assign w_sampY = COORD_W'({i_birdY[COORD_W-1], i_birdY} + c_sampleOfs);

  always_comb begin
    w_next     = r_state;
    w_clear    = 1'b0;
    w_write    = 1'b0;
    w_frameInc = 1'b0;
    if (i_clearTrail) begin
      w_next  = IDLE;
      w_clear = 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          w_clear = 1'b1;
          if (i_birdActive) w_next = RECORD;
        end
        RECORD: begin
          // Ending the flight takes precedence over a same-cycle sample.
          if (i_collision || !i_birdActive) begin
            if (KEEP_ON_COLLISION != 0) begin
              w_next = HOLD;
            end else begin
              w_next  = IDLE;
              w_clear = 1'b1;
            end
          end else if (i_startOfFrame) begin
            if (r_frameCnt == c_lastFrame) w_write    = 1'b1;
            else                           w_frameInc = 1'b1;
          end
        end
        HOLD: begin
          if (i_birdActive && !r_birdActPrev) begin
            w_next  = IDLE;
            w_clear = 1'b1;
          end
        end
        default: begin
          w_next  = IDLE;
          w_clear = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state       <= IDLE;
      r_valid       <= '0;
      r_wrPtr       <= '0;
      r_frameCnt    <= '0;
      r_dotCount    <= '0;
      r_birdActPrev <= 1'b0;
      r_trailDR     <= 1'b0;
      r_dotAge      <= '0;
    end else begin
      r_state       <= w_next;
      r_birdActPrev <= i_birdActive;
      r_trailDR     <= w_hit;
      r_dotAge      <= w_age;
      if (w_clear) begin
        r_valid    <= '0;
        r_wrPtr    <= '0;
        r_frameCnt <= '0;
        r_dotCount <= '0;
      end else if (w_write) begin
        r_valid[r_wrPtr] <= 1'b1;
        r_wrPtr          <= r_wrPtr + AGE_W'(1);
        r_frameCnt       <= '0;
        if (r_dotCount != c_full) r_dotCount <= r_dotCount + (AGE_W+1)'(1);
      end else if (w_frameInc) begin
        r_frameCnt <= r_frameCnt + FC_W'(1);
      end
    end
  end

  // Coordinates are qualified by r_valid, so they need no reset.
  always_ff @(posedge clk) begin
    if (w_write) begin
      r_dotX[r_wrPtr] <= w_sampX;
      r_dotY[r_wrPtr] <= w_sampY;
    end
  end

  trail_hit_test #(
    .NUM_DOTS (NUM_DOTS),
    .DOT_SIZE (DOT_SIZE),
    .COORD_W  (COORD_W)
  ) u_hit (
    .i_valid  (r_valid),
    .i_dotX   (r_dotX),
    .i_dotY   (r_dotY),
    .i_wrPtr  (r_wrPtr),
    .i_pixelX (i_pixelX),
    .i_pixelY (i_pixelY),
    .o_hit    (w_hit),
    .o_age    (w_age)
  );

  assign o_trailDR  = r_trailDR;
  assign o_dotAge   = r_dotAge;
  assign o_dotCount = r_dotCount;

endmodule
`default_nettype wire
